lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 4-bit LFSR state word.
- Samples the LFSR output on each enabled cycle and checks that every sample is the legal successor of the previous one.
- Measures the sequence period and detects the all-zero lock-up state.
- Exposes status for the bench and for any higher-level monitor.

Parameters:
WIDTH, 4, width of the LFSR state word.
TAPS, 4'b1100, feedback tap mask (bits 3 and 2, x^4+x^3+1); bit i set means state bit i feeds the XOR.
PW, 16, width of the period counter and the period output.
CW, 8, width of the saturating error counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- clear  input  1  synchronous clear, same effect as rst.
- en  input  1  lfsr_in is a valid sample this cycle.
- lfsr_in  input  WIDTH  LFSR state word from the upstream LFSR.
- period  output  PW  last measured period, in samples.
- period_valid  output  1  period holds a measurement for the current lock.
- seq_error  output  1  one-cycle pulse on an illegal transition.
- lockup  output  1  sticky flag: an all-zero sample was seen.
- error_count  output  CW  saturating count of seq_error events.

Behaviour:
- Successor rule: next(s) = {s[WIDTH-2:0], ^(s & TAPS)}, a Fibonacci left shift with the new bit entering at bit 0.
- All outputs are registered. A sample on edge N is reflected in the outputs after edge N.
- Reset (rst async, or clear sync) sets state=IDLE and clears period, period_valid, seq_error, lockup, error_count, the internal ref/prev registers and cnt to 0.
- Priority: rst > clear > en.
- en=0: all registers hold, except seq_error, which is driven 0.
- Zero sample, any state, en=1, lfsr_in==0:
  - lockup<=1 (sticky) and period_valid<=0.
  - state<=IDLE.
  - No seq_error, no error_count increment.
- IDLE, en=1, nonzero sample: ref<=sample, prev<=sample, cnt<=0, state<=MEASURE.
- MEASURE/LOCKED, en=1, nonzero sample, sample != next(prev):
  - seq_error<=1 for one cycle.
  - error_count<=error_count+1, saturating at 2^CW-1.
  - period_valid<=0.
  - Resync: ref<=sample, prev<=sample, cnt<=0, state<=MEASURE.
- MEASURE, en=1, sample == next(prev):
  - prev<=sample.
  - If sample==ref: period<=cnt+1, period_valid<=1, cnt<=0, state<=LOCKED.
  - Otherwise: cnt<=cnt+1, saturating at 2^PW-1. A saturated cnt stays in MEASURE, and no period is reported until the sequence returns to ref.
- LOCKED, en=1, sample == next(prev):
  - prev<=sample.
  - cnt<=0 when sample==ref, else cnt+1.
  - period and period_valid hold.
- Period counts accepted samples, not clock cycles; en gaps do not affect it.
- lockup clears only on rst or clear.
- rst asserted mid-measurement forces all outputs to 0 immediately, with no clock edge required.

Test Plan:
- Reset:
  - Stimulus: assert rst with clk stopped, then release; drive en=0 for 3 cycles.
  - Required: all outputs 0, and they stay 0.
- Full sequence:
  - Stimulus: en=1, feed 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001.
  - Required: after the 16th sample, period=15 and period_valid=1; seq_error never asserts; error_count=0.
- Illegal transition:
  - Stimulus: feed 0001,0010, then 0111 instead of 0100, then the legal chain continuing from 0111.
  - Required: seq_error pulses for exactly 1 cycle and error_count=1; period_valid stays 0 until 0111 recurs 15 samples later, then period=15.
- Lock-up:
  - Stimulus: after locking (period_valid=1), feed 0000, then the full sequence.
  - Required: lockup=1 and period_valid=0 the cycle after 0000; period re-measures to 15; lockup stays 1 until clear, which zeroes all outputs.
- Enable gaps:
  - Stimulus: feed the full sequence with en toggling 1/0 every cycle and garbage on lfsr_in while en=0.
  - Required: period=15, no seq_error.
- Saturation:
  - Stimulus: CW=2; inject 5 illegal transitions.
  - Required: 5 seq_error pulses; error_count ends at 3.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Watches a 4-bit Fibonacci LFSR stream, flags illegal successor transitions,
// measures the sequence period in accepted samples and latches all-zero lock-up.
module lfsr_seq_checker #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1100,
  parameter int                 PW    = 16,
  parameter int                 CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] lfsr_in,
  output logic [PW-1:0]    period,
  output logic             period_valid,
  output logic             seq_error,
  output logic             lockup,
  output logic [CW-1:0]    error_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] r_prev;
  logic [PW-1:0]    r_cnt;
  logic [PW-1:0]    r_period;
  logic             r_periodValid;
  logic             r_seqError;
  logic             r_lockup;
  logic [CW-1:0]    r_errorCount;

  logic [WIDTH-1:0] w_next;
  logic             w_zero;
  logic             w_legal;
  logic             w_atRef;
  logic [PW-1:0]    w_cntInc;
  logic [CW-1:0]    w_errInc;

  // Expected successor of the last accepted sample: shift left, feedback into bit 0.
  assign w_next   = {r_prev[WIDTH-2:0], ^(r_prev & TAPS)};
  assign w_zero   = (lfsr_in == '0);
  assign w_legal  = (lfsr_in == w_next);
  assign w_atRef  = (lfsr_in == r_ref);
  assign w_cntInc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_errInc = (r_errorCount == '1) ? r_errorCount : r_errorCount + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ref         <= '0;
      r_prev        <= '0;
      r_cnt         <= '0;
      r_period      <= '0;
      r_periodValid <= 1'b0;
      r_seqError    <= 1'b0;
      r_lockup      <= 1'b0;
      r_errorCount  <= '0;
    end else if (clear) begin
      r_state       <= IDLE;
      r_ref         <= '0;
      r_prev        <= '0;
      r_cnt         <= '0;
      r_period      <= '0;
      r_periodValid <= 1'b0;
      r_seqError    <= 1'b0;
      r_lockup      <= 1'b0;
      r_errorCount  <= '0;
    end else begin
      r_seqError <= 1'b0;
      if (en) begin
        if (w_zero) begin
          r_lockup      <= 1'b1;
          r_periodValid <= 1'b0;
          r_state       <= IDLE;
        end else if (r_state != MEASURE && r_state != LOCKED) begin
          r_ref   <= lfsr_in;
          r_prev  <= lfsr_in;
          r_cnt   <= '0;
          r_state <= MEASURE;
        end else if (!w_legal) begin
          // Resynchronise on the offending sample so measurement restarts from it.
          r_seqError    <= 1'b1;
          r_errorCount  <= w_errInc;
          r_periodValid <= 1'b0;
          r_ref         <= lfsr_in;
          r_prev        <= lfsr_in;
          r_cnt         <= '0;
          r_state       <= MEASURE;
        end else if (r_state == MEASURE) begin
          r_prev <= lfsr_in;
          if (w_atRef) begin
            r_period      <= r_cnt + 1'b1;
            r_periodValid <= 1'b1;
            r_cnt         <= '0;
            r_state       <= LOCKED;
          end else begin
            r_cnt <= w_cntInc;
          end
        end else begin
          r_prev <= lfsr_in;
          r_cnt  <= w_atRef ? '0 : w_cntInc;
        end
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_periodValid;
  assign seq_error    = r_seqError;
  assign lockup       = r_lockup;
  assign error_count  = r_errorCount;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed scenarios plus a randomized
// stream compared against a queue-based model of the checker's rules.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        clkRun = 1'b0;
  logic        rst, clear, en, en2;
  logic [3:0]  lfsrIn, lfsrIn2;
  logic [15:0] period, period2;
  logic        periodValid, seqError, lockup;
  logic        periodValid2, seqError2, lockup2;
  logic [7:0]  errorCount;
  logic [1:0]  errorCount2;

  int errors = 0;
  int checks = 0;

  // Reference model state: history of accepted samples since the last resync.
  int  hist[$];
  int  mPeriod, mEc;
  bit  mPv, mSe, mLk;
  int  fullSeq[16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

  lfsr_seq_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .en(en), .lfsr_in(lfsrIn),
    .period(period), .period_valid(periodValid), .seq_error(seqError),
    .lockup(lockup), .error_count(errorCount)
  );

  lfsr_seq_checker #(.CW(2)) dutSat (
    .clk(clk), .rst(rst), .clear(clear), .en(en2), .lfsr_in(lfsrIn2),
    .period(period2), .period_valid(periodValid2), .seq_error(seqError2),
    .lockup(lockup2), .error_count(errorCount2)
  );

  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  function automatic int succ(input int s);
    return ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
  endfunction

  task automatic modelReset();
    hist.delete();
    mPeriod = 0; mEc = 0; mPv = 0; mSe = 0; mLk = 0;
  endtask

  task automatic modelStep(input bit e, input int s);
    mSe = 0;
    if (e) begin
      if (s == 0) begin
        mLk = 1; mPv = 0; hist.delete();
      end else if (hist.size() == 0) begin
        hist.push_back(s);
      end else if (s != succ(hist[hist.size()-1])) begin
        mSe = 1; if (mEc < 255) mEc++; mPv = 0;
        hist.delete(); hist.push_back(s);
      end else if (s == hist[0]) begin
        if (!mPv) begin mPeriod = hist.size(); mPv = 1; end
        hist.delete(); hist.push_back(s);
      end else begin
        hist.push_back(s);
      end
    end
  endtask

  task automatic cycle(input bit e, input logic [3:0] s);
    en = e; lfsrIn = s;
    @(posedge clk); #1;
    modelStep(e, int'(s));
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; en = 1'b0; en2 = 1'b0; lfsrIn = '0; lfsrIn2 = '0;
    #3;
    checks++;
    if ({period, periodValid, seqError, lockup, errorCount} !== '0) begin
      errors++; $display("FAIL reset_stopped_clk: got %h expected 0", {period, periodValid, seqError, lockup, errorCount});
    end
    rst = 1'b0; clkRun = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'($urandom));
      checks++;
      if ({period, periodValid, seqError, lockup, errorCount} !== '0) begin
        errors++; $display("FAIL reset_idle_%0d: got %h expected 0", i, {period, periodValid, seqError, lockup, errorCount});
      end
    end
    cycle(1'b1, 4'd1); cycle(1'b1, 4'd2); cycle(1'b1, 4'd7); cycle(1'b1, 4'd0);
    checks++;
    if (lockup !== 1'b1 || errorCount !== 8'd1) begin
      errors++; $display("FAIL reset_pre_state: got lockup=%b count=%0d expected lockup=1 count=1", lockup, errorCount);
    end
    clkRun = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if ({period, periodValid, seqError, lockup, errorCount} !== '0) begin
      errors++; $display("FAIL reset_async_mid: got %h expected 0", {period, periodValid, seqError, lockup, errorCount});
    end
    rst = 1'b0; clkRun = 1'b1;
    modelReset();
  endtask

  task automatic test_full_sequence();
    doClear();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(fullSeq[i]));
      checks++;
      if (seqError !== mSe || periodValid !== mPv) begin
        errors++; $display("FAIL full_step_%0d: got err=%b pv=%b expected err=%b pv=%b", i, seqError, periodValid, mSe, mPv);
      end
    end
    checks++;
    if (period !== 16'd15 || periodValid !== 1'b1 || errorCount !== 8'd0) begin
      errors++; $display("FAIL full_result: got period=%0d pv=%b count=%0d expected 15 1 0", period, periodValid, errorCount);
    end
  endtask

  task automatic test_illegal();
    int s;
    int pulses;
    doClear();
    pulses = 0;
    cycle(1'b1, 4'd1); cycle(1'b1, 4'd2); cycle(1'b1, 4'd7);
    checks++;
    if (seqError !== 1'b1 || errorCount !== 8'd1) begin
      errors++; $display("FAIL illegal_pulse: got err=%b count=%0d expected err=1 count=1", seqError, errorCount);
    end
    s = 7;
    for (int i = 1; i <= 15; i++) begin
      s = succ(s);
      cycle(1'b1, 4'(s));
      if (seqError) pulses++;
      checks++;
      if (periodValid !== (i == 15)) begin
        errors++; $display("FAIL illegal_pv_%0d: got %b expected %b", i, periodValid, (i == 15));
      end
    end
    checks++;
    if (pulses != 0 || period !== 16'd15 || errorCount !== 8'd1) begin
      errors++; $display("FAIL illegal_result: got extra=%0d period=%0d count=%0d expected 0 15 1", pulses, period, errorCount);
    end
  endtask

  task automatic test_lockup();
    doClear();
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(fullSeq[i]));
    cycle(1'b1, 4'd0);
    checks++;
    if (lockup !== 1'b1 || periodValid !== 1'b0 || seqError !== 1'b0 || errorCount !== 8'd0) begin
      errors++; $display("FAIL lockup_zero: got lk=%b pv=%b err=%b count=%0d expected 1 0 0 0", lockup, periodValid, seqError, errorCount);
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(fullSeq[i]));
    checks++;
    if (period !== 16'd15 || periodValid !== 1'b1 || lockup !== 1'b1) begin
      errors++; $display("FAIL lockup_remeasure: got period=%0d pv=%b lk=%b expected 15 1 1", period, periodValid, lockup);
    end
    doClear();
    checks++;
    if ({period, periodValid, seqError, lockup, errorCount} !== '0) begin
      errors++; $display("FAIL lockup_clear: got %h expected 0", {period, periodValid, seqError, lockup, errorCount});
    end
  endtask

  task automatic test_enable_gaps();
    int pulses;
    doClear();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(fullSeq[i]));
      if (seqError) pulses++;
      cycle(1'b0, 4'($urandom));
      if (seqError) pulses++;
    end
    checks++;
    if (pulses != 0 || period !== 16'd15 || periodValid !== 1'b1) begin
      errors++; $display("FAIL gaps_result: got pulses=%0d period=%0d pv=%b expected 0 15 1", pulses, period, periodValid);
    end
  endtask

  task automatic test_random();
    int last;
    int r;
    int v;
    int bad;
    doClear();
    last = 1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 72) v = succ(last);
      else if (r < 78) v = 0;
      else v = $urandom_range(1, 15);
      if (v != 0) last = v;
      cycle($urandom_range(0, 3) != 0, 4'(v));
      checks++;
      if (period !== 16'(mPeriod) || periodValid !== mPv || seqError !== mSe ||
          lockup !== mLk || errorCount !== 8'(mEc)) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL random_%0d: got p=%0d pv=%b e=%b lk=%b c=%0d expected p=%0d pv=%b e=%b lk=%b c=%0d",
                   i, period, periodValid, seqError, lockup, errorCount, mPeriod, mPv, mSe, mLk, mEc);
      end
      if (i == 200) doClear();
    end
  endtask

  task automatic test_saturation();
    int prev;
    int v;
    int pulses;
    doClear();
    pulses = 0;
    prev = $urandom_range(1, 15);
    en2 = 1'b1; lfsrIn2 = 4'(prev);
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      do v = $urandom_range(1, 15); while (v == succ(prev));
      lfsrIn2 = 4'(v);
      prev = v;
      @(posedge clk); #1;
      if (seqError2) pulses++;
      checks++;
      if (errorCount2 !== 2'((k > 3) ? 3 : k)) begin
        errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", k, errorCount2, (k > 3) ? 3 : k);
      end
    end
    en2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pulses != 5 || seqError2 !== 1'b0 || errorCount2 !== 2'd3) begin
      errors++; $display("FAIL sat_result: got pulses=%0d err=%b count=%0d expected 5 0 3", pulses, seqError2, errorCount2);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_illegal();
    test_lockup();
    test_enable_gaps();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
